// File: rtl/i2s_rx_deserializer_pkg.sv
// Shared types and constants for the I2S receive deserializer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package i2s_rx_pkg;

  // Slot tracking: wait for first LRCK edge, skip the I2S delay bit,
  // shift sample bits, then discard slot padding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    SHIFT = 2'd2,
    WAIT  = 2'd3
  } rx_state_e;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

  // clk_i must run at least this many cycles per BCLK period.
  localparam int MIN_CLK_PER_BCLK = 4;

endpackage

// File: rtl/i2s_rx_deserializer_if.sv
// Sample output bus of the I2S deserializer: sample, signedness tag, channel.
// Latency: n/a (wiring only).
// Backpressure: valid/ready; producer holds all fields while valid && !ready.
//   master: drives sample_o, signed_o, chan_o, valid_o; receives ready_i.
//   slave : the consumer side (signed_data_extend).
interface i2s_rx_deserializer_if #(
  parameter int S_WD = 16
);
  logic [S_WD-1:0] sample_o;
  logic            signed_o;
  logic            chan_o;
  logic            valid_o;
  logic            ready_i;

  modport master (
    output sample_o,
    output signed_o,
    output chan_o,
    output valid_o,
    input  ready_i
  );

  modport slave (
    input  sample_o,
    input  signed_o,
    input  chan_o,
    input  valid_o,
    output ready_i
  );
endinterface

// File: rtl/i2s_rx_deserializer_sync_edge_det.sv
// Multi-flop synchroniser for async inputs plus a rising-edge pulse on one of them.
// Latency: STAGES cycles through the chain; rise fires in the cycle the synced edge_in first reads 1.
// Backpressure: none.
//   edge_in : synchronised and edge-detected (BCLK)
//   din     : synchronised only (LRCK, SDATA), kept in lockstep with edge_in
//   dsync   : synchronised din
//   rise    : one-cycle pulse on a synchronised 0->1 of edge_in
module sync_edge_det #(
  parameter int W      = 2,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         edge_in,
  input  logic [W-1:0] din,
  output logic [W-1:0] dsync,
  output logic         rise
);

  // All bits share one chain so data stays aligned with the clock it belongs to.
  logic [STAGES-1:0][W:0] stg;
  logic                   edge_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg    <= '0;
      edge_q <= 1'b0;
    end else begin
      stg    <= {stg[STAGES-2:0], {din, edge_in}};
      edge_q <= stg[STAGES-1][0];
    end
  end

  assign dsync = stg[STAGES-1][W:1];
  assign rise  = stg[STAGES-1][0] & ~edge_q;

endmodule

// File: rtl/i2s_rx_deserializer.sv
// I2S receiver: recovers one MSB-first, left-aligned S_WD-bit sample per LRCK slot.
// Latency: valid_o rises 2 clk_i cycles after the synchronised BCLK rise carrying the last bit.
// Backpressure: valid/ready; a sample completing while the output is stalled is dropped and sets sticky overrun_o.
//   clk_i/rst_ni           : system clock (>= 4x BCLK), async active-low reset
//   bclk_i/lrck_i/sdata_i  : async codec serial inputs
//   signed_i               : format tag, registered alongside each sample
//   out_if                 : sample_o/signed_o/chan_o/valid_o/ready_i
//   overrun_o              : sticky drop flag, cleared only by reset
// Optional: I2S_RX_LJ_EN adds lj_i; lj_i = 1 selects left-justified framing (no delay bit).
module i2s_rx_deserializer
  import i2s_rx_pkg::*;
#(
  parameter int S_WD        = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  bclk_i,
  input  logic                  lrck_i,
  input  logic                  sdata_i,
  input  logic                  signed_i,
`ifdef I2S_RX_LJ_EN
  input  logic                  lj_i,
`endif
  i2s_rx_deserializer_if.master out_if,
  output logic                  overrun_o
);

  localparam int CNT_W = $clog2(S_WD + 1);

  logic lj_mode;
`ifdef I2S_RX_LJ_EN
  assign lj_mode = lj_i;
`else
  assign lj_mode = 1'b0;
`endif

  // ---------------------------------------------------------------- sync
  logic       bclk_rise;
  logic [1:0] data_sync;
  logic       lrck_s;
  logic       sdata_s;

  sync_edge_det #(
    .W      (2),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .edge_in (bclk_i),
    .din     ({sdata_i, lrck_i}),
    .dsync   (data_sync),
    .rise    (bclk_rise)
  );

  assign lrck_s  = data_sync[0];
  assign sdata_s = data_sync[1];

  // LRCK is only meaningful at BCLK rises. lrck_seen blocks a false edge
  // on the very first rise after reset, when there is no previous sample.
  logic lrck_smp;
  logic lrck_seen;
  logic lrck_edge;

  assign lrck_edge = bclk_rise && lrck_seen && (lrck_s != lrck_smp);

  // ---------------------------------------------------------------- FSM
  rx_state_e       state, state_d;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_d;
  logic [S_WD-1:0] shreg, shreg_d;
  chan_e           cur_chan, cur_chan_d;
  logic            start_slot;
  logic            commit;
  logic [S_WD-1:0] commit_dat;
  chan_e           commit_chan;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d     = state;
    bit_cnt_d   = bit_cnt;
    shreg_d     = shreg;
    cur_chan_d  = cur_chan;
    start_slot  = 1'b0;
    commit      = 1'b0;
    commit_dat  = shreg;
    commit_chan = cur_chan;

    case (state)
      IDLE: start_slot = lrck_edge;

      // The rise that revealed the LRCK edge carried the I2S delay bit,
      // so the next rise already holds the MSB: just clear and go.
      DELAY: begin
        bit_cnt_d = '0;
        shreg_d   = '0;
        state_d   = SHIFT;
      end

      SHIFT: begin
        if (lrck_edge) begin
          // Short slot: left-align what arrived, zero-fill the LSBs.
          start_slot = 1'b1;
          commit     = (bit_cnt != '0);
          commit_dat = shreg << (CNT_W'(S_WD) - bit_cnt);
        end else if (bclk_rise) begin
          shreg_d   = {shreg[S_WD-2:0], sdata_s};
          bit_cnt_d = bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(S_WD - 1)) begin
            commit     = 1'b1;
            commit_dat = {shreg[S_WD-2:0], sdata_s};
            state_d    = WAIT;
          end
        end
      end

      WAIT: start_slot = lrck_edge;

      default: state_d = IDLE;
    endcase

    // Slot entry shared by IDLE, SHIFT and WAIT. In left-justified mode
    // the edge rise itself carries the MSB.
    if (start_slot) begin
      cur_chan_d = chan_e'(lrck_s);
      if (lj_mode) begin
        state_d   = SHIFT;
        bit_cnt_d = CNT_W'(1);
        shreg_d   = {{(S_WD-1){1'b0}}, sdata_s};
      end else begin
        state_d   = DELAY;
      end
    end
  end

  // ---------------------------------------------------------------- datapath
  // Completed samples are parked one cycle before the output stage.
  logic            pend_vld;
  logic [S_WD-1:0] pend_dat;
  chan_e           pend_chan;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      cur_chan  <= CH_LEFT;
      lrck_smp  <= 1'b0;
      lrck_seen <= 1'b0;
      pend_vld  <= 1'b0;
      pend_dat  <= '0;
      pend_chan <= CH_LEFT;
    end else begin
      bit_cnt  <= bit_cnt_d;
      shreg    <= shreg_d;
      cur_chan <= cur_chan_d;
      pend_vld <= commit;
      if (commit) begin
        pend_dat  <= commit_dat;
        pend_chan <= commit_chan;
      end
      if (bclk_rise) begin
        lrck_smp  <= lrck_s;
        lrck_seen <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- output
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_if.sample_o <= '0;
      out_if.signed_o <= 1'b0;
      out_if.chan_o   <= 1'b0;
      out_if.valid_o  <= 1'b0;
      overrun_o       <= 1'b0;
    end else if (pend_vld) begin
      if (!out_if.valid_o || out_if.ready_i) begin
        out_if.sample_o <= pend_dat;
        out_if.signed_o <= signed_i;
        out_if.chan_o   <= pend_chan;
        out_if.valid_o  <= 1'b1;
      end else begin
        overrun_o <= 1'b1;
      end
    end else if (out_if.valid_o && out_if.ready_i) begin
      out_if.valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Directed bench for i2s_rx_deserializer: S_WD = 16, 32 BCLK per slot, clk = 8x BCLK.
// Latency: n/a.
// Backpressure: ready driven per scenario.
module tb_i2s_rx_deserializer;

  logic clk;
  logic rst_n;
  logic bclk;
  logic lrck;
  logic sdata;
  logic sgn;
`ifdef I2S_RX_LJ_EN
  logic lj;
`endif
  logic overrun;

  i2s_rx_deserializer_if #(.S_WD(16)) bus ();

  i2s_rx_deserializer #(
    .S_WD        (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .bclk_i    (bclk),
    .lrck_i    (lrck),
    .sdata_i   (sdata),
    .signed_i  (sgn),
`ifdef I2S_RX_LJ_EN
    .lj_i      (lj),
`endif
    .out_if    (bus),
    .overrun_o (overrun)
  );

  // Edges at 7,17,... (rise) and 12,22,... (fall); stimulus moves on multiples of 10.
  initial begin
    clk = 1'b0;
    #2;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        g;
  } xfer_t;

  xfer_t q[$];
  int    vld_cycles = 0;
  int    checks = 0;
  int    errors = 0;

  always @(negedge clk) begin
    if (bus.valid_o) vld_cycles++;
    if (bus.valid_o && bus.ready_i)
      q.push_back({bus.sample_o, bus.chan_o, bus.signed_o});
  end

  // One BCLK period: change on the falling edge, receiver samples on the rise.
  task automatic send_bit(input logic lr, input logic d);
    bclk = 1'b0; lrck = lr; sdata = d;
    #40;
    bclk = 1'b1;
    #40;
  endtask

  // Slot positions p_from..p_to; I2S puts the MSB at p=1, left-justified at p=0.
  task automatic send_slot(input logic lr, input logic [15:0] w, input int nbits,
                           input int p_from, input int p_to, input logic lj_fmt);
    logic d;
    for (int p = p_from; p <= p_to; p++) begin
      d = 1'b0;
      if (lj_fmt) begin
        if (p < nbits) d = w[nbits-1-p];
      end else if (p >= 1 && p <= nbits) begin
        d = w[nbits-p];
      end
      send_bit(lr, d);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bclk = 1'b0; lrck = 1'b1; sdata = 1'b0; sgn = 1'b1;
    bus.ready_i = 1'b1;
`ifdef I2S_RX_LJ_EN
    lj = 1'b0;
`endif
    #30;
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", bus.valid_o); end
    checks++; if (bus.sample_o !== 16'h0000) begin errors++; $display("FAIL rst_sample got %h want 0000", bus.sample_o); end
    checks++; if (bus.chan_o !== 1'b0) begin errors++; $display("FAIL rst_chan got %b want 0", bus.chan_o); end
    checks++; if (bus.signed_o !== 1'b0) begin errors++; $display("FAIL rst_signed got %b want 0", bus.signed_o); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got %b want 0", overrun); end
    #10;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int    base;
    int    v0;
    xfer_t got;
    base = q.size();
    v0   = vld_cycles;
    send_slot(1'b1, 16'h0000, 16, 28, 31, 1'b0);   // tail of a right slot
    send_slot(1'b0, 16'h8001, 16, 0, 31, 1'b0);
    send_slot(1'b1, 16'h7FFE, 16, 0, 31, 1'b0);
    checks++; if (q.size() - base !== 2) begin errors++; $display("FAIL basic_count got %0d want 2", q.size() - base); end
    got = (q.size() > base) ? q[base] : 'x;
    checks++; if (got !== {16'h8001, 1'b0, 1'b1}) begin errors++; $display("FAIL basic_left got %h/%b/%b want 8001/0/1", got.s, got.c, got.g); end
    got = (q.size() > base + 1) ? q[base+1] : 'x;
    checks++; if (got !== {16'h7FFE, 1'b1, 1'b1}) begin errors++; $display("FAIL basic_right got %h/%b/%b want 7ffe/1/1", got.s, got.c, got.g); end
    checks++; if (vld_cycles - v0 !== 2) begin errors++; $display("FAIL basic_valid_cycles got %0d want 2", vld_cycles - v0); end
  endtask

  task automatic test_reset_mid_slot();
    int    base;
    xfer_t got;
    rst_n = 1'b0;
    send_slot(1'b1, 16'hFFFF, 16, 0, 4, 1'b0);
    rst_n = 1'b1;
    base = q.size();
    send_slot(1'b1, 16'hFFFF, 16, 5, 31, 1'b0);
    checks++; if (q.size() - base !== 0) begin errors++; $display("FAIL midrst_partial got %0d outputs want 0", q.size() - base); end
    send_slot(1'b0, 16'h1357, 16, 0, 31, 1'b0);
    checks++; if (q.size() - base !== 1) begin errors++; $display("FAIL midrst_count got %0d want 1", q.size() - base); end
    got = (q.size() > base) ? q[base] : 'x;
    checks++; if (got !== {16'h1357, 1'b0, 1'b1}) begin errors++; $display("FAIL midrst_first got %h/%b/%b want 1357/0/1", got.s, got.c, got.g); end
  endtask

  task automatic test_short_slot();
    int    base;
    xfer_t got;
    sgn  = 1'b0;
    base = q.size();
    send_slot(1'b1, 16'h0ABC, 12, 0, 12, 1'b0);    // delay bit + 12 data bits
    send_slot(1'b0, 16'h0F0F, 16, 0, 31, 1'b0);
    checks++; if (q.size() - base !== 2) begin errors++; $display("FAIL short_count got %0d want 2", q.size() - base); end
    got = (q.size() > base) ? q[base] : 'x;
    checks++; if (got !== {16'hABC0, 1'b1, 1'b0}) begin errors++; $display("FAIL short_sample got %h/%b/%b want abc0/1/0", got.s, got.c, got.g); end
    got = (q.size() > base + 1) ? q[base+1] : 'x;
    checks++; if (got !== {16'h0F0F, 1'b0, 1'b0}) begin errors++; $display("FAIL short_next got %h/%b/%b want 0f0f/0/0", got.s, got.c, got.g); end
  endtask

  task automatic test_overrun();
    int    base;
    xfer_t got;
    bus.ready_i = 1'b0;
    send_slot(1'b1, 16'h1111, 16, 0, 31, 1'b0);
    checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL ovr_valid1 got %b want 1", bus.valid_o); end
    checks++; if (bus.sample_o !== 16'h1111) begin errors++; $display("FAIL ovr_sample1 got %h want 1111", bus.sample_o); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got %b want 0", overrun); end
    send_slot(1'b0, 16'h2222, 16, 0, 31, 1'b0);
    checks++; if (bus.sample_o !== 16'h1111) begin errors++; $display("FAIL ovr_held got %h want 1111", bus.sample_o); end
    checks++; if (bus.chan_o !== 1'b1) begin errors++; $display("FAIL ovr_chan got %b want 1", bus.chan_o); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", overrun); end
    base = q.size();
    bus.ready_i = 1'b1;
    #30;
    got = (q.size() > base) ? q[base] : 'x;
    checks++; if (got !== {16'h1111, 1'b1, 1'b0}) begin errors++; $display("FAIL ovr_drain got %h/%b/%b want 1111/1/0", got.s, got.c, got.g); end
    checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL ovr_valid_drop got %b want 0", bus.valid_o); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", overrun); end
  endtask

  task automatic test_async_reset();
    int    base;
    xfer_t got;
    send_slot(1'b1, 16'h5A5A, 16, 0, 7, 1'b0);
    rst_n = 1'b0;
    #4;
    checks++; if (bus.sample_o !== 16'h0000) begin errors++; $display("FAIL arst_sample got %h want 0000", bus.sample_o); end
    checks++; if (bus.chan_o !== 1'b0) begin errors++; $display("FAIL arst_chan got %b want 0", bus.chan_o); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL arst_overrun got %b want 0", overrun); end
    #16;
    rst_n = 1'b1;
    base = q.size();
    send_slot(1'b1, 16'h5A5A, 16, 8, 31, 1'b0);
    checks++; if (q.size() - base !== 0) begin errors++; $display("FAIL arst_partial got %0d outputs want 0", q.size() - base); end
    send_slot(1'b0, 16'hC3C3, 16, 0, 31, 1'b0);
    checks++; if (q.size() - base !== 1) begin errors++; $display("FAIL arst_count got %0d want 1", q.size() - base); end
    got = (q.size() > base) ? q[base] : 'x;
    checks++; if (got !== {16'hC3C3, 1'b0, 1'b0}) begin errors++; $display("FAIL arst_next got %h/%b/%b want c3c3/0/0", got.s, got.c, got.g); end
  endtask

`ifdef I2S_RX_LJ_EN
  task automatic test_left_justified();
    int    base;
    xfer_t got;
    lj   = 1'b1;
    base = q.size();
    send_slot(1'b1, 16'h1234, 16, 0, 31, 1'b1);
    checks++; if (q.size() - base !== 1) begin errors++; $display("FAIL lj_count got %0d want 1", q.size() - base); end
    got = (q.size() > base) ? q[base] : 'x;
    checks++; if (got !== {16'h1234, 1'b1, 1'b0}) begin errors++; $display("FAIL lj_sample got %h/%b/%b want 1234/1/0", got.s, got.c, got.g); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_reset_mid_slot();
    test_short_slot();
    test_overrun();
    test_async_reset();
`ifdef I2S_RX_LJ_EN
    test_left_justified();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
